// File: rtl/amc_frame_ctrl.sv
// rtl/amc_frame_ctrl.sv - frame sequencer: header parse, demod select, LSB-first byte packing
module amc_frame_ctrl #(
   parameter int DEMOD_LAT = 1,
   parameter int TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_in,
   input  logic [4:0] q_in,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic [4:0] dm_i,
   output logic [4:0] dm_q,
   output logic [1:0] sel,
   input  logic [3:0] bits_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       frame_done,
   output logic       frame_err
);

   typedef enum logic [2:0] {HDR, HDR_WAIT, PAY, PAY_WAIT, EMIT, DONE} state_t;

   localparam logic [1:0] LAT_INIT = 2'(DEMOD_LAT - 1);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        armed;        // low only for the first cycle after reset release
   logic [1:0]  lat_cnt;      // cycles left until bits_in is valid for the in-flight symbol
   logic [2:0]  hdr_cnt;      // header symbols captured so far
   logic [4:0]  hdr_sr;       // h0..h4, oldest in the MSB
   logic [4:0]  rem;          // payload symbols still to capture
   logic [11:0] acc;          // packed payload bits, LSB first
   logic [3:0]  cnt;          // valid bits in acc
   logic [7:0]  to_cnt;       // consecutive idle cycles mid-frame

   logic        accept, lat_done, idle, timeout_hit;
   logic [5:0]  hdr_next;
   logic [3:0]  mask, k;
   logic [11:0] acc_cap, acc_sh;
   logic [3:0]  cnt_cap, cnt_sh;
   logic [4:0]  rem_cap;

   assign dm_i       = i_in;
   assign dm_q       = q_in;
   assign sym_ready  = armed && (state == HDR || state == PAY);
   assign accept     = sym_valid && sym_ready;
   assign lat_done   = (lat_cnt == 2'd0);
   assign byte_valid = (state == EMIT);
   assign byte_out   = (state == EMIT) ? acc[7:0] : 8'd0;
   assign frame_done = (state == DONE);

   // Idle means a frame is open and no symbol is taken this cycle.
   assign idle        = ((state == HDR && hdr_cnt != 3'd0) || state == PAY) && !accept;
   assign timeout_hit = idle && (to_cnt == TO_LAST);

   assign hdr_next = {hdr_sr, bits_in[0]};
   assign k        = {2'b00, sel} + 4'd1;
   assign acc_cap  = acc | ({8'd0, bits_in & mask} << cnt);
   assign cnt_cap  = cnt + k;
   assign rem_cap  = rem - 5'd1;
   assign acc_sh   = {8'd0, acc[11:8]};
   assign cnt_sh   = (cnt >= 4'd8) ? cnt - 4'd8 : 4'd0;

   // Keep only the k low bits the selected modulation actually produces.
   always_comb begin
      mask = 4'b0001;
      case (sel)
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         2'b10:   mask = 4'b0111;
         default: mask = 4'b1111;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HDR;
      else        state <= state_nxt;
   end

   // Next-state logic: symbol intake, capture decisions, emit and frame close.
   always_comb begin
      state_nxt = state;
      case (state)
         HDR: begin
            if (timeout_hit)  state_nxt = HDR;
            else if (accept)  state_nxt = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (lat_done) state_nxt = (hdr_cnt == 3'd5) ? PAY : HDR;
         end
         PAY: begin
            if (timeout_hit)  state_nxt = HDR;
            else if (accept)  state_nxt = PAY_WAIT;
         end
         PAY_WAIT: begin
            if (lat_done) begin
               if (cnt_cap >= 4'd8)     state_nxt = EMIT;
               else if (rem_cap == 5'd0) state_nxt = (cnt_cap != 4'd0) ? EMIT : DONE;
               else                     state_nxt = PAY;
            end
         end
         EMIT: begin
            if (byte_ready) begin
               if (rem == 5'd0) state_nxt = (cnt_sh != 4'd0) ? EMIT : DONE;
               else             state_nxt = PAY;
            end
         end
         DONE:    state_nxt = HDR;
         default: state_nxt = HDR;
      endcase
   end

   // Datapath: latency wait, header shift, payload accumulate, byte drain, timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         lat_cnt   <= 2'd0;
         hdr_cnt   <= 3'd0;
         hdr_sr    <= 5'd0;
         rem       <= 5'd0;
         acc       <= 12'd0;
         cnt       <= 4'd0;
         to_cnt    <= 8'd0;
         sel       <= 2'b00;
         frame_err <= 1'b0;
      end else begin
         armed     <= 1'b1;
         frame_err <= timeout_hit;
         to_cnt    <= (idle && !timeout_hit) ? to_cnt + 8'd1 : 8'd0;
         if (timeout_hit) begin
            hdr_cnt <= 3'd0;
            rem     <= 5'd0;
            acc     <= 12'd0;
            cnt     <= 4'd0;
            sel     <= 2'b00;
         end else begin
            case (state)
               HDR, PAY: begin
                  if (accept) lat_cnt <= LAT_INIT;
               end
               HDR_WAIT: begin
                  if (!lat_done) begin
                     lat_cnt <= lat_cnt - 2'd1;
                  end else begin
                     hdr_sr <= hdr_next[4:0];
                     if (hdr_cnt == 3'd5) begin
                        hdr_cnt <= 3'd0;
                        sel     <= hdr_next[5:4];
                        rem     <= {1'b0, hdr_next[3:0]} + 5'd1;
                        acc     <= 12'd0;
                        cnt     <= 4'd0;
                     end else begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                     end
                  end
               end
               PAY_WAIT: begin
                  if (!lat_done) begin
                     lat_cnt <= lat_cnt - 2'd1;
                  end else begin
                     acc <= acc_cap;
                     cnt <= cnt_cap;
                     rem <= rem_cap;
                  end
               end
               EMIT: begin
                  if (byte_ready) begin
                     acc <= acc_sh;
                     cnt <= cnt_sh;
                  end
               end
               DONE: begin
                  sel <= 2'b00;
                  acc <= 12'd0;
                  cnt <= 4'd0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
